sub_bytes_pipe: RTL and testbench
=================================

// Module: sub_bytes_pipe
// PURPOSE
//   Parametrised, elastic AES SubBytes / InvSubBytes stage. Every byte lane of a DATA_W-bit state goes through
//   the forward or inverse S-box in PIPE registered stages. Beats enter and leave on valid/ready handshakes
//   with full backpressure. Mode and TAG_W sideband travel with each beat.
//   Sits between AddRoundKey and ShiftRows in the round datapath. Replaces the fixed 4-word done-pulse stage.
// PARAMETERS
//   DATA_W  128  state width in bits; multiple of 8; NLANE = DATA_W/8 S-box lanes
//   PIPE    2    pipeline depth in stages, 1..4; stage 0 holds the registered input, stage PIPE-1 drives out_*
//   TAG_W   4    opaque sideband width (round/stream id), passed through unchanged
// PORTS
//   clk        in   1       rising-edge clock
//   reset      in   1       asynchronous, active-low reset
//   in_valid   in   1       input beat valid
//   in_ready   out  1       stage can accept a beat this cycle
//   in_data    in   DATA_W  state; byte i = in_data[8i+7:8i]
//   in_encrypt in   1       1 = forward S-box, 0 = inverse S-box (per beat)
//   in_tag     in   TAG_W   sideband
//   out_valid  out  1       output beat valid
//   out_ready  in   1       downstream accepts
//   out_data   out  DATA_W  substituted state, same byte order
//   out_tag    out  TAG_W   tag of the beat on out_data
//   busy       out  1       OR of all stage valid bits
//   beat_cnt   out  16      count of beats accepted at input; wraps 0xFFFF->0
// BEHAVIOUR
//   - Reset (reset=0, async assert, sync deassert by system): all stage valids=0, out_valid=0, busy=0, beat_cnt=0.
//     out_data and out_tag are 0. Any in-flight beats are discarded. First accept is possible in the first
//     cycle after deassertion.
//   - Transfer happens when valid&&ready at a rising edge. Upstream must hold in_* stable while in_valid=1 and in_ready=0.
//   - Stage k holds v[k], data, encrypt, tag. Stage k advances when v[k]=1 and (k is last ? out_ready : !v[k+1] || adv[k+1]).
//   - Stage k loads when its predecessor advances. Stage 0 loads on input accept.
//   - in_ready = !v[0] || adv[0]. This is combinational from out_ready (no skid). Input data never feeds output combinationally.
//   - The S-box lookup sits between stage 0 and stage 1. Stages 1..PIPE-1 are delay registers.
//     If PIPE=1, the lookup lies between the input and stage 0.
//   - Latency: accepted at edge t -> out_valid=1 after edge t+PIPE-1 when not stalled.
//     With PIPE=2, a beat accepted at edge t is presented for the cycle after edge t+1.
//   - Throughput: 1 beat/cycle with out_ready held 1. No bubbles are inserted.
//   - Stall: out_valid=0 never occurs while a beat is held. out_data and out_tag stay stable while out_valid=1 and out_ready=0.
//   - Full pipeline (all v=1) with out_ready=0: in_ready=0.
//   - Full pipeline with simultaneous out_ready=1 and in_valid=1: one beat leaves, one enters in the same cycle.
//   - Empty pipeline: out_valid=0, busy=0, in_ready=1.
//   - Mode is latched per beat. Beats of mixed encrypt/decrypt may be interleaved back-to-back, each correctly substituted.
//   - beat_cnt increments by 1 per input accept (16-bit unsigned, modular). It is not affected by output stalls.
//   - Beats are never reordered, dropped or duplicated.
// STRUCTURE
//   - Shared package aes_pkg holds:
//     * SBOX_FWD[256] and SBOX_INV[256] byte constant tables (FIPS-197)
//     * localparam AES_BLK_W=128
//     * function sbox_sel(byte, enc)
//   - One sub-module, aes_sbox_lane: 8-bit combinational forward/inverse lookup with encrypt select.
//     It is instantiated NLANE times in a generate loop.
//   - Stage valid/advance logic is a generate loop over PIPE. No other hierarchy.
// TESTING
//   1. Reset: hold reset=0 with in_valid=1 -> in_ready=1 after release; out_valid=0, busy=0, beat_cnt=0.
//   2. Forward, DATA_W=128, PIPE=2: in_data=0x00112233445566778899aabbccddeeff, enc=1, tag=5
//      -> out_data=0x638293c31bfc33f5c4eeacea4bc12816, tag=5, out_valid 1 cycle after accept edge.
//   3. Inverse round-trip: feed test-2 output with enc=0 -> 0x00112233445566778899aabbccddeeff.
//      Also check all-0x63 -> all-0x00.
//   4. Backpressure: stream 8 beats back-to-back, out_ready=0 for cycles 3-6.
//      -> in_ready falls when full; every out beat is held stable; order and count are exact; beat_cnt=8.
//   5. Mixed mode and full throughput: alternate enc=1/0 on 0x53 bytes, out_ready=1
//      -> outputs alternate all-0xED / all-0x50 every cycle with no bubbles.
//   6. Reset mid-stream: assert reset with 2 beats in flight -> out_valid=0 at once (async).
//      No stale beat appears after release. Repeat with PIPE=1 and DATA_W=32.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants: FIPS-197 forward/inverse S-box tables and a lane lookup helper.
package aes_pkg;

  localparam int unsigned AES_BLK_W = 128;

  // Entry b lives at index b; index 0 is the leftmost byte of the literal.
  localparam logic [0:255][7:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox_sel(input logic [7:0] b, input logic enc);
    return enc ? SBOX_FWD[b] : SBOX_INV[b];
  endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// One byte lane: combinational forward or inverse S-box lookup.
module aes_sbox_lane
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
  input  logic       encrypt_i,
  output logic [7:0] data_o
);

  assign data_o = sbox_sel(data_i, encrypt_i);

endmodule

// File: rtl/sub_bytes_pipe.sv
// Elastic SubBytes/InvSubBytes stage: PIPE valid/ready register stages, lookup after stage 0
// (or at the input when PIPE=1), mode and tag carried per beat.
module sub_bytes_pipe
  import aes_pkg::*;
#(
  parameter int unsigned DATA_W = AES_BLK_W,
  parameter int unsigned PIPE   = 2,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_encrypt,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy,
  output logic [15:0]       beat_cnt
);

  localparam int unsigned NLANE = DATA_W / 8;

  logic [PIPE-1:0]   v;
  logic [PIPE-1:0]   adv;
  logic [PIPE-1:0]   load;
  logic              go;
  logic [DATA_W-1:0] stage_data [PIPE];
  logic [TAG_W-1:0]  stage_tag  [PIPE];
  logic [DATA_W-1:0] sbox_in;
  logic [DATA_W-1:0] sbox_out;
  logic              sbox_enc;
  logic [15:0]       cnt_q, cnt_d;

  // Readiness ripples from the output back to the input in one pass.
  always_comb begin
    adv  = '0;
    load = '0;
    go   = out_ready;
    for (int k = int'(PIPE) - 1; k >= 0; k--) begin
      adv[k] = v[k] & go;
      go     = ~v[k] | adv[k];
    end
    in_ready = go;
    load[0]  = in_valid & go;
    for (int k = 1; k < int'(PIPE); k++) begin
      load[k] = adv[k-1];
    end
  end

  if (PIPE == 1) begin : g_lookup_in
    assign sbox_in  = in_data;
    assign sbox_enc = in_encrypt;
  end else begin : g_lookup_s0
    logic enc0_q, enc0_d;

    always_comb begin
      enc0_d = enc0_q;
      if (load[0]) enc0_d = in_encrypt;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) enc0_q <= 1'b0;
      else        enc0_q <= enc0_d;
    end

    assign sbox_in  = stage_data[0];
    assign sbox_enc = enc0_q;
  end

  for (genvar i = 0; i < int'(NLANE); i++) begin : g_lane
    aes_sbox_lane u_lane (
      .data_i    (sbox_in[8*i +: 8]),
      .encrypt_i (sbox_enc),
      .data_o    (sbox_out[8*i +: 8])
    );
  end

  for (genvar k = 0; k < int'(PIPE); k++) begin : g_stage
    logic              v_q, v_d;
    logic [DATA_W-1:0] data_q, data_d, data_src;
    logic [TAG_W-1:0]  tag_q, tag_d, tag_src;

    if (k == 0) begin : g_first
      assign data_src = (PIPE == 1) ? sbox_out : in_data;
      assign tag_src  = in_tag;
    end else begin : g_rest
      assign data_src = (k == 1) ? sbox_out : stage_data[k-1];
      assign tag_src  = stage_tag[k-1];
    end

    // Payload only moves on load so a stalled output stays stable.
    always_comb begin
      v_d    = load[k] | (v_q & ~adv[k]);
      data_d = data_q;
      tag_d  = tag_q;
      if (load[k]) begin
        data_d = data_src;
        tag_d  = tag_src;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        v_q    <= 1'b0;
        data_q <= '0;
        tag_q  <= '0;
      end else begin
        v_q    <= v_d;
        data_q <= data_d;
        tag_q  <= tag_d;
      end
    end

    assign v[k]          = v_q;
    assign stage_data[k] = data_q;
    assign stage_tag[k]  = tag_q;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load[0]) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign out_valid = v[PIPE-1];
  assign out_data  = stage_data[PIPE-1];
  assign out_tag   = stage_tag[PIPE-1];
  assign busy      = |v;
  assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_sub_bytes_pipe.sv
// Bench for sub_bytes_pipe: GF(2^8)-derived S-box model with a per-cycle scoreboard on two
// configurations (128/2 and 32/1) plus directed literal vectors.
module tb_sub_bytes_pipe;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic         a_iv, a_ir, a_enc, a_ov, a_or, a_busy;
  logic [127:0] a_id, a_od;
  logic [3:0]   a_it, a_ot;
  logic [15:0]  a_cnt;

  logic         b_iv, b_ir, b_enc, b_ov, b_or, b_busy;
  logic [31:0]  b_id, b_od;
  logic [3:0]   b_it, b_ot;
  logic [15:0]  b_cnt;

  sub_bytes_pipe #(.DATA_W(128), .PIPE(2), .TAG_W(4)) u_dut_a (
    .clk(clk), .reset(reset), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .in_encrypt(a_enc), .in_tag(a_it), .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
    .out_tag(a_ot), .busy(a_busy), .beat_cnt(a_cnt)
  );

  sub_bytes_pipe #(.DATA_W(32), .PIPE(1), .TAG_W(4)) u_dut_b (
    .clk(clk), .reset(reset), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .in_encrypt(b_enc), .in_tag(b_it), .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
    .out_tag(b_ot), .busy(b_busy), .beat_cnt(b_cnt)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]   m_fwd [256];
  logic [7:0]   m_inv [256];
  logic [131:0] qa [$];
  logic [131:0] qb [$];
  logic         hold_v [2];
  logic [131:0] hold_x [2];
  int           mcnt [2];

  localparam logic [127:0] V0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V1 = 128'h638293c31bfc33f5c4eeacea4bc12816;

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p = 8'h00;
    logic [7:0] a = x;
    logic [7:0] b = y;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [127:0] model_sub(input logic [127:0] d, input logic enc, input int nb);
    logic [127:0] r = '0;
    for (int i = 0; i < nb; i++) r[8*i +: 8] = enc ? m_fwd[d[8*i +: 8]] : m_inv[d[8*i +: 8]];
    return r;
  endfunction

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic mon(input int id, input logic iv, input logic ir, input logic [127:0] idat,
                     input logic enc, input logic [3:0] itag, input logic ov, input logic ordy,
                     input logic [127:0] od, input logic [3:0] ot, input logic bsy,
                     input logic [15:0] cnt, input int nb);
    logic [131:0] exp;
    int sz;
    if (!reset) begin
      chk("rst_out_valid", ov, 1'b0);
      chk("rst_busy", bsy, 1'b0);
      chk("rst_beat_cnt", cnt, 16'd0);
      chk("rst_out_data_tag", {ot, od}, 132'd0);
      if (id == 0) qa.delete(); else qb.delete();
      hold_v[id] = 1'b0;
      mcnt[id] = 0;
      return;
    end
    sz = (id == 0) ? qa.size() : qb.size();
    chk("busy", bsy, sz != 0);
    chk("beat_cnt", cnt, 16'(mcnt[id]));
    if (hold_v[id]) chk("held_beat", {ov, ot, od}, {1'b1, hold_x[id]});
    if (ov && sz == 0) chk("stale_beat", ov, 1'b0);
    else if (ov && ordy) begin
      exp = (id == 0) ? qa.pop_front() : qb.pop_front();
      chk("out_beat", {ot, od}, exp);
    end
    hold_v[id] = ov && !ordy;
    hold_x[id] = {ot, od};
    if (iv && ir) begin
      if (id == 0) qa.push_back({itag, model_sub(idat, enc, nb)});
      else         qb.push_back({itag, model_sub(idat, enc, nb)});
      mcnt[id]++;
    end
  endtask

  always @(negedge clk) begin
    mon(0, a_iv, a_ir, a_id, a_enc, a_it, a_ov, a_or, a_od, a_ot, a_busy, a_cnt, 16);
    mon(1, b_iv, b_ir, {96'd0, b_id}, b_enc, b_it, b_ov, b_or, {96'd0, b_od}, b_ot, b_busy,
        b_cnt, 4);
  end

  task automatic send_a(input logic [127:0] d, input logic e, input logic [3:0] t);
    bit ok = 1'b0;
    a_iv = 1'b1; a_id = d; a_enc = e; a_it = t;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk); ok = a_ir;
      @(posedge clk); #1;
    end
    a_iv = 1'b0;
    if (!ok) chk("send_a_timeout", ok, 1'b1);
  endtask

  task automatic send_b(input logic [31:0] d, input logic e, input logic [3:0] t);
    bit ok = 1'b0;
    b_iv = 1'b1; b_id = d; b_enc = e; b_it = t;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk); ok = b_ir;
      @(posedge clk); #1;
    end
    b_iv = 1'b0;
    if (!ok) chk("send_b_timeout", ok, 1'b1);
  endtask

  task automatic wait_out_a(input string name, input logic [127:0] d, input logic [3:0] t);
    bit seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk); seen = a_ov;
      if (seen) chk(name, {a_ot, a_od}, {t, d});
    end
    if (!seen) chk({name, "_timeout"}, seen, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] inv, s;
    logic [127:0] bp [8];
    int sent, c;
    bit acc, stall_seen;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      m_fwd[x] = s;
      m_inv[s] = 8'(x);
    end
    chk("model_fwd_00", m_fwd[0], 8'h63);
    chk("model_fwd_53", m_fwd[8'h53], 8'hed);
    chk("model_inv_53", m_inv[8'h53], 8'h50);
    chk("model_vec", model_sub(V0, 1'b1, 16), V1);

    a_iv = 1'b1; a_id = V0; a_enc = 1'b1; a_it = 4'd5; a_or = 1'b1;
    b_iv = 1'b0; b_id = '0; b_enc = 1'b0; b_it = '0; b_or = 1'b1;

    // Reset held with a pending input, then first beat and its latency.
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("t1_in_ready", a_ir, 1'b1);
    chk("t1_out_valid", a_ov, 1'b0);
    chk("t1_busy", a_busy, 1'b0);
    chk("t1_beat_cnt", a_cnt, 16'd0);
    @(posedge clk); #1 a_iv = 1'b0;
    @(negedge clk);
    chk("t2_latency_not_yet", a_ov, 1'b0);
    chk("t2_beat_cnt", a_cnt, 16'd1);
    @(negedge clk);
    chk("t2_out_valid", a_ov, 1'b1);
    chk("t2_fwd_vec", {a_ot, a_od}, {4'd5, V1});
    @(posedge clk); #1;

    // Inverse round trip and all-0x63.
    send_a(V1, 1'b0, 4'd9);
    wait_out_a("t3_inv_vec", V0, 4'd9);
    send_a({16{8'h63}}, 1'b0, 4'd2);
    wait_out_a("t3_inv_63", 128'd0, 4'd2);

    // Backpressure: 8 beats, out_ready low for cycles 3..6.
    pulse_reset();
    for (int i = 0; i < 8; i++) bp[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    sent = 0; c = 0; stall_seen = 1'b0;
    while ((sent < 8 || a_busy) && c < 100) begin
      a_or = !(c >= 3 && c <= 6);
      a_iv = (sent < 8);
      if (sent < 8) begin a_id = bp[sent]; a_enc = sent[0]; a_it = 4'(sent); end
      @(negedge clk);
      if (a_iv && !a_ir) stall_seen = 1'b1;
      acc = a_iv && a_ir;
      @(posedge clk); #1;
      if (acc) sent++;
      c++;
    end
    a_iv = 1'b0; a_or = 1'b1;
    chk("t4_stall_seen", stall_seen, 1'b1);
    chk("t4_beat_cnt", a_cnt, 16'd8);
    chk("t4_drained", qa.size(), 0);

    // Mixed mode at full rate: one beat per cycle, no bubbles.
    for (int k = 0; k < 10; k++) begin
      a_iv = (k < 8);
      a_id = {16{8'h53}}; a_enc = !k[0]; a_it = 4'(k);
      @(negedge clk);
      if (k < 8) chk("t5_in_ready", a_ir, 1'b1);
      if (k >= 2) begin
        chk("t5_out_valid", a_ov, 1'b1);
        chk("t5_out_data", a_od, (k % 2 == 0) ? {16{8'hed}} : {16{8'h50}});
      end
      @(posedge clk); #1;
    end
    a_iv = 1'b0;

    // Config B: 32-bit lanes, single stage, zero extra latency.
    send_b(32'h00112233, 1'b1, 4'd3);
    @(negedge clk);
    chk("b_latency", {b_ov, b_ot, b_od}, {1'b1, 4'd3, 32'h638293c3});
    @(posedge clk); #1;
    send_b(32'h638293c3, 1'b0, 4'd4);
    @(negedge clk);
    chk("b_inv_vec", {b_ov, b_ot, b_od}, {1'b1, 4'd4, 32'h00112233});
    @(posedge clk); #1;
    // Sweep every byte value both ways through config B.
    for (int i = 0; i < 128; i++) begin
      b_iv = 1'b1; b_enc = (i < 64);
      b_id = {8'(4*(i%64)+3), 8'(4*(i%64)+2), 8'(4*(i%64)+1), 8'(4*(i%64))};
      b_it = 4'(i);
      @(negedge clk);
      chk("b_sweep_ready", b_ir, 1'b1);
      @(posedge clk); #1;
    end
    b_iv = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Mid-stream async reset with beats held in both pipes.
    a_or = 1'b0; b_or = 1'b0;
    a_iv = 1'b1; a_id = V0; a_enc = 1'b1; a_it = 4'd1;
    b_iv = 1'b1; b_id = 32'h01020304; b_enc = 1'b1; b_it = 4'd1;
    @(posedge clk); #1;
    a_id = V1; a_it = 4'd2;
    @(posedge clk); #1;
    chk("t6_a_full", a_ov, 1'b1);
    chk("t6_b_full", b_ov, 1'b1);
    #2 reset = 1'b0;
    #1;
    a_iv = 1'b0; b_iv = 1'b0;
    chk("t6_a_async_ov", a_ov, 1'b0);
    chk("t6_a_async_busy", a_busy, 1'b0);
    chk("t6_a_async_data", a_od, 128'd0);
    chk("t6_b_async_ov", b_ov, 1'b0);
    chk("t6_b_async_busy", b_busy, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1; a_or = 1'b1; b_or = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t6_a_no_stale", a_ov, 1'b0);
      chk("t6_b_no_stale", b_ov, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
